// File: rtl/fmes_pkg.sv
// Shared types and register map for the multi-channel frequency meter.
`timescale 1ns/1ps
package fmes_pkg;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_GATE, S_CONV, S_DONE} state_e;

    localparam int          CH_STRIDE = 8;
    localparam logic [15:0] ADR_STAT  = 16'h00F0;
    localparam logic [15:0] ADR_OVF_L = 16'h00F1;
    localparam logic [15:0] ADR_OVF_H = 16'h00F2;
    localparam int          DW        = 32;

    // Big-endian byte pick: offset 0 is the most significant byte.
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fmes_multi_ch_b2bcd.sv
// Sequential shift-add-3 binary to BCD converter: one load cycle, then one bit per clock.
`timescale 1ns/1ps
module bin_to_bcd_seq #(
    parameter int CW = 16,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ld_i,
    input  logic [CW-1:0] bin_i,
    output logic [DW-1:0] dec_o,
    output logic          done_o
);
    localparam int NW = $clog2(CW + 1);

    logic [CW-1:0] sh_q, sh_d;
    logic [DW-1:0] dec_q, dec_d, adj;
    logic [NW-1:0] cnt_q, cnt_d;

    always_comb begin
        adj = dec_q;
        for (int i = 0; i < DW / 4; i++)
            if (dec_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = dec_q[4*i +: 4] + 4'd3;
        sh_d  = sh_q;
        dec_d = dec_q;
        cnt_d = cnt_q;
        if (ld_i) begin
            sh_d  = bin_i;
            dec_d = '0;
            cnt_d = NW'(CW);
        end else if (cnt_q != '0) begin
            dec_d = {adj[DW-2:0], sh_q[CW-1]};
            sh_d  = {sh_q[CW-2:0], 1'b0};
            cnt_d = cnt_q - NW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_q  <= '0;
            dec_q <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            dec_q <= dec_d;
            cnt_q <= cnt_d;
        end
    end

    // Flags the final shift; dec_o holds the result from the next cycle on.
    assign dec_o  = dec_q;
    assign done_o = (cnt_q == NW'(1));

endmodule

// File: rtl/fmes_multi_ch.sv
// Multi-channel gated frequency meter with shared BCD converter and byte-wide register read port.
`timescale 1ns/1ps
module fmes_multi_ch #(
    parameter int CH      = 4,
    parameter int CW      = 16,
    parameter int GATE_US = 1000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce1us_i,
    input  logic [CH-1:0] ux_i,
    input  logic          st_i,
    input  logic          cont_i,
    input  logic [15:0]   rd_adr_i,
    output logic [7:0]    rd_dat_o,
    output logic          busy_o,
    output logic          ok_o,
    output logic [CH-1:0] ovf_o
);
    import fmes_pkg::*;

    localparam int GW  = $clog2(GATE_US + 1);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    state_e                  state_q, state_d;
    logic [CHW-1:0]          ch_q, ch_d;
    logic                    conv_ld_q, conv_ld_d;
    logic [GW-1:0]           gate_q;
    logic                    gate_end;
    logic [CH-1:0]           s1_q, s2_q, s3_q, edge_w;
    logic [CH-1:0][CW-1:0]   cnt_q, pub_bin_q;
    logic [CH-1:0][DW-1:0]   wdec_q, pub_dec_q;
    logic [CH-1:0]           wovf_q, pub_ovf_q;
    logic                    ok_q;
    logic                    cv_ld, cv_done;
    logic [CW-1:0]           cv_bin;
    logic [DW-1:0]           cv_dec;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= ux_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_w   = s2_q & ~s3_q;
    assign gate_end = ce1us_i && (gate_q == GW'(GATE_US - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            conv_ld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            conv_ld_q <= conv_ld_d;
        end
    end

    // Next channel is loaded in the same cycle the previous one finishes, so each takes CW+1 clk.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        conv_ld_d = conv_ld_q;
        cv_ld     = 1'b0;
        case (state_q)
            S_IDLE: if (st_i) state_d = S_ARM;
            S_ARM:  if (ce1us_i) state_d = S_GATE;
            S_GATE: if (gate_end) begin
                state_d   = S_CONV;
                ch_d      = '0;
                conv_ld_d = 1'b1;
            end
            S_CONV: begin
                cv_ld     = conv_ld_q;
                conv_ld_d = 1'b0;
                if (cv_done) begin
                    if (ch_q == CHW'(CH - 1)) state_d = S_DONE;
                    else begin
                        ch_d      = ch_q + CHW'(1);
                        conv_ld_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = cont_i ? S_ARM : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            wovf_q <= '0;
            gate_q <= '0;
        end else if (state_q == S_ARM) begin
            cnt_q  <= '0;
            wovf_q <= '0;
            gate_q <= '0;
        end else if (state_q == S_GATE) begin
            if (ce1us_i) gate_q <= gate_q + GW'(1);
            for (int i = 0; i < CH; i++)
                if (edge_w[i]) begin
                    if (&cnt_q[i]) wovf_q[i] <= 1'b1;
                    else           cnt_q[i]  <= cnt_q[i] + CW'(1);
                end
        end
    end

    assign cv_bin = cnt_q[ch_q];

    bin_to_bcd_seq #(.CW(CW), .DW(DW)) u_b2bcd (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ld_i   (cv_ld),
        .bin_i  (cv_bin),
        .dec_o  (cv_dec),
        .done_o (cv_done)
    );

    // Last channel's result is still in the converter during DONE, so it is published from there.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdec_q    <= '0;
            pub_bin_q <= '0;
            pub_dec_q <= '0;
            pub_ovf_q <= '0;
            ok_q      <= 1'b0;
        end else begin
            ok_q <= (state_q == S_DONE);
            if (state_q == S_CONV && conv_ld_q && ch_q != '0)
                wdec_q[ch_q - CHW'(1)] <= cv_dec;
            if (state_q == S_DONE) begin
                pub_bin_q <= cnt_q;
                pub_ovf_q <= wovf_q;
                for (int i = 0; i < CH; i++)
                    pub_dec_q[i] <= (i == CH - 1) ? cv_dec : wdec_q[i];
            end
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign ok_o   = ok_q;
    assign ovf_o  = pub_ovf_q;

    logic [CW-1:0] sel_bin;
    logic [DW-1:0] sel_dec;
    logic [31:0]   bin32;
    logic [15:0]   ovf16;
    logic          hit;

    always_comb begin
        sel_bin = '0;
        sel_dec = '0;
        hit     = 1'b0;
        for (int i = 0; i < CH; i++)
            if (rd_adr_i >= 16'(i * CH_STRIDE) && rd_adr_i < 16'((i + 1) * CH_STRIDE)) begin
                hit     = 1'b1;
                sel_bin = pub_bin_q[i];
                sel_dec = pub_dec_q[i];
            end
        bin32           = '0;
        bin32[CW-1:0]   = sel_bin;
        ovf16           = '0;
        ovf16[CH-1:0]   = pub_ovf_q;
        rd_dat_o        = '0;
        if (rd_adr_i == ADR_STAT)       rd_dat_o = {busy_o, 7'b0};
        else if (rd_adr_i == ADR_OVF_L) rd_dat_o = ovf16[7:0];
        else if (rd_adr_i == ADR_OVF_H) rd_dat_o = ovf16[15:8];
        else if (hit)                   rd_dat_o = be_byte(rd_adr_i[2] ? sel_dec : bin32, rd_adr_i[1:0]);
    end

endmodule
